// File: rtl/fan_thermal_sched_pkg.sv
// Shared types and zone tables for the fan thermal scheduler.
package fan_thermal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_WAIT,
    S_REQ,
    S_RESP_WAIT,
    S_EVAL
  } state_t;

  localparam int unsigned NUM_ZONES = 5;
  localparam int unsigned ZONE_W    = 3;

  typedef logic [ZONE_W-1:0] zone_t;

  // Lower temperature bound (degC) of zone z+1, i.e. the step-up threshold out of zone z
  function automatic int th_of(zone_t z);
    case (z)
      3'd0:    th_of = 40;
      3'd1:    th_of = 55;
      3'd2:    th_of = 70;
      default: th_of = 85;
    endcase
  endfunction

  function automatic logic [7:0] dz_of(zone_t z);
    case (z)
      3'd0:    dz_of = 8'd60;
      3'd1:    dz_of = 8'd100;
      3'd2:    dz_of = 8'd150;
      3'd3:    dz_of = 8'd190;
      default: dz_of = 8'd222;
    endcase
  endfunction

  // Multi-step zone move: climb while at/above threshold, fall only below threshold minus hysteresis
  function automatic zone_t next_zone(zone_t z, logic signed [7:0] t, int hyst);
    zone_t nz;
    nz = z;
    for (int unsigned i = 0; i < NUM_ZONES - 1; i++) begin
      if (nz < zone_t'(NUM_ZONES - 1) && int'(t) >= th_of(nz))
        nz = nz + 1'b1;
    end
    for (int unsigned i = 0; i < NUM_ZONES - 1; i++) begin
      if (nz > '0 && int'(t) < th_of(nz - 1'b1) - hyst)
        nz = nz - 1'b1;
    end
    return nz;
  endfunction

endpackage

// File: rtl/fan_thermal_sched_if.sv
// Start/done handshake to the I2C temperature controller.
interface fan_thermal_sched_if;
  logic       i2c_start;
  logic       i2c_done;
  logic [7:0] i2c_rd_data;

  modport master (output i2c_start, input i2c_done, input i2c_rd_data);
  modport slave  (input i2c_start, output i2c_done, output i2c_rd_data);
endinterface

// File: rtl/fan_thermal_sched_duty_slew.sv
// Slew-limited fan duty register: 1 LSB per strobe toward target, instant jump to max on force.
module duty_slew #(
  parameter int unsigned DUTY_DEFAULT = 50,
  parameter int unsigned DUTY_MAX     = 222
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] target,
  input  logic       force_max,
  input  logic       step,
  output logic [7:0] duty
);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      duty <= 8'(DUTY_DEFAULT);
    end else if (force_max) begin
      duty <= 8'(DUTY_MAX);
    end else if (step) begin
      if (duty < target)
        duty <= duty + 8'd1;
      else if (duty > target)
        duty <= duty - 8'd1;
    end
  end

endmodule

// File: rtl/fan_thermal_sched.sv
// Periodic I2C temperature poll, zone mapping with hysteresis, failsafe and slewed fan duty.
module fan_thermal_sched
  import fan_thermal_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = 7_812_500,
  parameter int unsigned TIMEOUT_CYCLES = 78_125,
  parameter int unsigned RAMP_CYCLES    = 78_125,
  parameter int unsigned FAIL_LIMIT     = 3,
  parameter int unsigned HYST_C         = 2,
  parameter int unsigned DUTY_DEFAULT   = 50,
  parameter int unsigned DUTY_MAX       = 222
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  fan_thermal_sched_if.master bus,
  output logic [7:0]          fan_duty,
  output logic [7:0]          temp_c,
  output logic                temp_valid,
  output logic [2:0]          zone,
  output logic                failsafe
);

  localparam int unsigned FW = $clog2(FAIL_LIMIT + 1);
  localparam int unsigned RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

  state_t        state;
  logic [22:0]   poll_cnt;
  logic [16:0]   to_cnt;
  logic [FW-1:0] fail_cnt;
  logic [RW-1:0] ramp_cnt;

  logic          ramp_step;
  logic          timeout_hit;
  logic [FW-1:0] fail_next;
  logic          fs_enter;
  logic [7:0]    target;

  always_comb begin
    ramp_step   = (ramp_cnt == RW'(RAMP_CYCLES - 1));
    timeout_hit = (state == S_RESP_WAIT) && !bus.i2c_done &&
                  (to_cnt == 17'(TIMEOUT_CYCLES - 1));
    fail_next   = (fail_cnt == FW'(FAIL_LIMIT)) ? fail_cnt : fail_cnt + 1'b1;
    // fs_enter lets the duty register jump on the same edge the failsafe flag sets
    fs_enter    = timeout_hit && (fail_next == FW'(FAIL_LIMIT));
    // With no reading yet, hold the default duty rather than ramping to the zone-0 level
    target      = temp_valid ? dz_of(zone) : 8'(DUTY_DEFAULT);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state         <= S_IDLE;
      poll_cnt      <= '0;
      to_cnt        <= '0;
      fail_cnt      <= '0;
      ramp_cnt      <= '0;
      failsafe      <= 1'b0;
      bus.i2c_start <= 1'b0;
      temp_valid    <= 1'b0;
      zone          <= '0;
      if (rst)
        temp_c <= '0;
    end else begin
      ramp_cnt      <= ramp_step ? '0 : ramp_cnt + 1'b1;
      bus.i2c_start <= 1'b0;
      case (state)
        S_IDLE: begin
          state    <= S_POLL_WAIT;
          poll_cnt <= '0;
        end
        S_POLL_WAIT: begin
          if (poll_cnt == 23'(POLL_CYCLES - 1)) begin
            poll_cnt      <= '0;
            state         <= S_REQ;
            bus.i2c_start <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        S_REQ: begin
          to_cnt <= '0;
          state  <= S_RESP_WAIT;
        end
        S_RESP_WAIT: begin
          if (bus.i2c_done) begin
            temp_c     <= bus.i2c_rd_data;
            temp_valid <= 1'b1;
            fail_cnt   <= '0;
            failsafe   <= 1'b0;
            state      <= S_EVAL;
          end else if (timeout_hit) begin
            fail_cnt <= fail_next;
            if (fs_enter)
              failsafe <= 1'b1;
            poll_cnt <= '0;
            state    <= S_POLL_WAIT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_EVAL: begin
          zone     <= next_zone(zone, $signed(temp_c), int'(HYST_C));
          poll_cnt <= '0;
          state    <= S_POLL_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  duty_slew #(
    .DUTY_DEFAULT(DUTY_DEFAULT),
    .DUTY_MAX    (DUTY_MAX)
  ) u_duty_slew (
    .clk      (clk),
    .rst      (rst),
    .en       (enable),
    .target   (target),
    .force_max(failsafe | fs_enter),
    .step     (ramp_step),
    .duty     (fan_duty)
  );

endmodule

// File: tb/tb_fan_thermal_sched.sv
// Directed bench for fan_thermal_sched with shortened poll/timeout/ramp periods.
module tb_fan_thermal_sched;

  localparam int unsigned T_TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] fan_duty;
  logic [7:0] temp_c;
  logic       temp_valid;
  logic [2:0] zone;
  logic       failsafe;

  fan_thermal_sched_if bus ();

  fan_thermal_sched #(
    .POLL_CYCLES   (100),
    .TIMEOUT_CYCLES(T_TO),
    .RAMP_CYCLES   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .fan_duty  (fan_duty),
    .temp_c    (temp_c),
    .temp_valid(temp_valid),
    .zone      (zone),
    .failsafe  (failsafe)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int starts      = 0;
  int replies     = 0;
  int pend        = 0;
  bit auto_on     = 1'b0;
  logic [7:0] auto_data = '0;

  task automatic check_vec(string tag, int unsigned got, int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  // Also acts as the auto-responder: replies 3 cycles after each start when enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.i2c_done = 1'b0;
    if (bus.i2c_start) starts++;
    if (!auto_on) begin
      pend = 0;
    end else if (bus.i2c_start) begin
      pend = 3;
    end else if (pend != 0) begin
      pend--;
      if (pend == 0) begin
        bus.i2c_done    = 1'b1;
        bus.i2c_rd_data = auto_data;
        replies++;
      end
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_start(string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      seen = bus.i2c_start;
    end
    check_vec(tag, seen, 1);
  endtask

  task automatic wait_reply(string tag);
    int r0 = replies;
    for (int i = 0; i < 300 && replies == r0; i++) tick();
    check_vec(tag, (replies != r0) ? 1 : 0, 1);
  endtask

  // Answer subsequent reads with d, then step past capture and EVAL
  task automatic apply_temp(logic [7:0] d);
    auto_data = d;
    auto_on   = 1'b1;
    wait_reply("reply_seen");
    ticks(2);
    check_vec("temp_c_upd", temp_c, d);
  endtask

  // Stop answering right after a reply so the next request is the first unanswered one
  task automatic quiesce_after_reply();
    wait_reply("quiesce_reply");
    auto_on = 1'b0;
    ticks(2);
  endtask

  task automatic wait_duty(string tag, logic [7:0] v, int budget);
    for (int i = 0; i < budget && fan_duty != v; i++) tick();
    check_vec(tag, fan_duty, v);
  endtask

  initial begin
    int n;
    int s0;
    logic [7:0] d;
    bit fs_seen;

    rst             = 1'b1;
    enable          = 1'b0;
    bus.i2c_done    = 1'b0;
    bus.i2c_rd_data = '0;
    ticks(3);
    check_vec("rst_duty", fan_duty, 50);
    check_vec("rst_start", bus.i2c_start, 0);
    check_vec("rst_temp", temp_c, 0);
    check_vec("rst_valid", temp_valid, 0);
    check_vec("rst_zone", zone, 0);
    check_vec("rst_fs", failsafe, 0);
    rst = 1'b0;
    tick();

    // First request: enable is sampled on the first edge, start rises 100 edges later
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && !bus.i2c_start; i++) begin
      tick();
      n++;
      if (n == 1) check_vec("en_duty", fan_duty, 50);
    end
    check_vec("first_start_latency", n - 1, 100);
    check_vec("pre_read_duty", fan_duty, 50);
    tick();
    check_vec("start_width", bus.i2c_start, 0);
    tick();
    bus.i2c_rd_data = 8'd60;
    bus.i2c_done    = 1'b1;
    tick();
    check_vec("t60_temp", temp_c, 60);
    check_vec("t60_valid", temp_valid, 1);
    tick();
    check_vec("t60_zone", zone, 2);

    // Ramp rate: exactly one LSB per 4 cycles, settling at 150
    auto_data = 8'd60;
    auto_on   = 1'b1;
    for (int i = 0; i < 20 && fan_duty == 8'd50; i++) tick();
    d = fan_duty;
    check_vec("ramp_first", d, 51);
    ticks(3);
    check_vec("ramp_hold", fan_duty, d);
    tick();
    check_vec("ramp_step", fan_duty, d + 8'd1);
    wait_duty("ramp_to_150", 8'd150, 1000);
    ticks(12);
    check_vec("ramp_settle_150", fan_duty, 150);

    // Hysteresis from zone 2
    apply_temp(8'd54);
    check_vec("hyst54_zone", zone, 2);
    apply_temp(8'd52);
    check_vec("hyst52_zone", zone, 1);
    wait_duty("ramp_to_100", 8'd100, 1000);
    ticks(8);
    check_vec("settle_100", fan_duty, 100);
    apply_temp(8'hF6);
    check_vec("neg_zone", zone, 0);
    wait_duty("ramp_to_60", 8'd60, 1000);

    // Three unanswered requests -> failsafe with duty jumping on the same edge
    quiesce_after_reply();
    s0      = starts;
    fs_seen = 1'b0;
    for (int i = 0; i < 600 && !fs_seen; i++) begin
      tick();
      fs_seen = failsafe;
    end
    check_vec("fs_set", fs_seen, 1);
    check_vec("fs_duty", fan_duty, 222);
    check_vec("fs_req_count", starts - s0, 3);
    apply_temp(8'd30);
    check_vec("fs_clear", failsafe, 0);
    check_vec("fs_recover_zone", zone, 0);
    wait_duty("fs_ramp_down", 8'd60, 1000);

    // done coincident with timeout expiry counts as success and clears fail_cnt
    quiesce_after_reply();
    wait_start("to_req1");
    wait_start("to_req2");
    wait_start("to_req3");
    ticks(T_TO);
    bus.i2c_rd_data = 8'd45;
    bus.i2c_done    = 1'b1;
    tick();
    check_vec("edge_temp", temp_c, 45);
    check_vec("edge_fs", failsafe, 0);
    tick();
    check_vec("edge_zone", zone, 1);
    wait_start("to_req4");
    wait_start("to_req5");
    wait_start("to_req6");
    check_vec("fail_cnt_cleared", failsafe, 0);
    ticks(2);
    bus.i2c_rd_data = 8'd45;
    bus.i2c_done    = 1'b1;
    tick();
    ticks(10);
    bus.i2c_rd_data = 8'd99;
    bus.i2c_done    = 1'b1;
    ticks(2);
    check_vec("stray_temp", temp_c, 45);
    check_vec("stray_zone", zone, 1);

    // Disable during RESP_WAIT, then a late done
    wait_start("dis_req");
    ticks(2);
    enable = 1'b0;
    tick();
    check_vec("dis_duty", fan_duty, 50);
    check_vec("dis_zone", zone, 0);
    check_vec("dis_valid", temp_valid, 0);
    check_vec("dis_fs", failsafe, 0);
    bus.i2c_rd_data = 8'd77;
    bus.i2c_done    = 1'b1;
    ticks(2);
    check_vec("late_done_temp", temp_c, 45);
    check_vec("dis_start", bus.i2c_start, 0);
    enable = 1'b1;
    ticks(30);
    check_vec("reen_duty", fan_duty, 50);

    // Reset in the middle of a climb toward zone 4
    apply_temp(8'd90);
    check_vec("t90_zone", zone, 4);
    ticks(40);
    check_vec("t90_ramping", (fan_duty > 8'd50) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    check_vec("mid_rst_duty", fan_duty, 50);
    check_vec("mid_rst_temp", temp_c, 0);
    check_vec("mid_rst_valid", temp_valid, 0);
    check_vec("mid_rst_zone", zone, 0);
    check_vec("mid_rst_fs", failsafe, 0);
    check_vec("mid_rst_start", bus.i2c_start, 0);
    rst     = 1'b0;
    auto_on = 1'b0;
    ticks(5);
    check_vec("post_rst_duty", fan_duty, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
